// File: rtl/spi_serf.sv
// SPI serf: oversampled 16-bit command/data frames, register file with read-only ID.
// Writes commit only when SS_n rises after exactly 16 SCLK rises.
module spi_serf #(
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h6A,
  parameter logic [6:0] WHO_AM_I_ADDR = 7'h0F,
  parameter int         NUM_REGS      = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        done,
  output logic [15:0] rx_frame,
  output logic        wr_strb,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] FULL = 3'd3;
  localparam logic [2:0] OVER = 3'd4;
  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

  logic [2:0]  ss_sync_r, sclk_sync_r;
  logic [1:0]  mosi_sync_r;
  logic [2:0]  state_r, state_nxt_s;
  logic [4:0]  cnt_r, cnt_nxt_s;
  logic [15:0] rx_r, rx_nxt_s, frame_r, frame_nxt_s;
  logic [7:0]  tx_r, tx_nxt_s, rd_val_s, wr_data_r, wr_data_nxt_s;
  logic        rnw_r, rnw_nxt_s;
  logic [6:0]  addr_r, addr_nxt_s, wr_addr_r, wr_addr_nxt_s;
  logic        done_r, done_nxt_s, wr_strb_r, wr_strb_nxt_s, we_s;
  logic        miso_r, miso_nxt_s;
  logic [7:0]  cmd_s;
  logic [7:0]  regs_r [NUM_REGS];
  logic        ss_fall_s, ss_rise_s, sclk_rise_s, sclk_fall_s, mosi_s;

  assign ss_fall_s   = !ss_sync_r[1] &&  ss_sync_r[2];
  assign ss_rise_s   =  ss_sync_r[1] && !ss_sync_r[2];
  assign sclk_rise_s =  sclk_sync_r[1] && !sclk_sync_r[2];
  assign sclk_fall_s = !sclk_sync_r[1] &&  sclk_sync_r[2];
  assign mosi_s      = mosi_sync_r[1];
  assign cmd_s       = {rx_r[6:0], mosi_s};

  // Read data for the command byte completing on this rise.
  always_comb begin
    rd_val_s = 8'h00;
    if (cmd_s[7] && cmd_s[6:0] == WHO_AM_I_ADDR) begin
      rd_val_s = WHO_AM_I_VAL;
    end else if (cmd_s[7] && cmd_s[6:0] < NUM_REGS_W) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cmd_s[6:0] == 7'(i)) rd_val_s = regs_r[i];
      end
    end else begin
      rd_val_s = 8'h00;
    end
  end

  // Frame FSM next-state; ss_rise takes priority over any SCLK edge.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    rx_nxt_s      = rx_r;
    tx_nxt_s      = tx_r;
    rnw_nxt_s     = rnw_r;
    addr_nxt_s    = addr_r;
    frame_nxt_s   = frame_r;
    done_nxt_s    = 1'b0;
    wr_strb_nxt_s = 1'b0;
    wr_addr_nxt_s = wr_addr_r;
    wr_data_nxt_s = wr_data_r;
    we_s          = 1'b0;
    if (state_r != IDLE && ss_rise_s) begin
      state_nxt_s = IDLE;
      if (state_r == FULL) begin
        done_nxt_s  = 1'b1;
        frame_nxt_s = rx_r;
        if (!rnw_r && addr_r < NUM_REGS_W) begin
          wr_strb_nxt_s = 1'b1;
          wr_addr_nxt_s = addr_r;
          wr_data_nxt_s = rx_r[7:0];
          we_s          = 1'b1;
        end else begin
          wr_strb_nxt_s = 1'b0;
        end
      end else begin
        done_nxt_s = 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (ss_fall_s) begin
            cnt_nxt_s   = 5'd0;
            tx_nxt_s    = 8'h00;
            state_nxt_s = CMD;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CMD: begin
          if (sclk_rise_s) begin
            rx_nxt_s  = {rx_r[14:0], mosi_s};
            cnt_nxt_s = cnt_r + 5'd1;
            if (cnt_r == 5'd7) begin
              rnw_nxt_s   = cmd_s[7];
              addr_nxt_s  = cmd_s[6:0];
              tx_nxt_s    = rd_val_s;
              state_nxt_s = DATA;
            end else begin
              state_nxt_s = CMD;
            end
          end else begin
            state_nxt_s = CMD;
          end
        end
        DATA: begin
          if (sclk_rise_s) begin
            rx_nxt_s    = {rx_r[14:0], mosi_s};
            cnt_nxt_s   = cnt_r + 5'd1;
            state_nxt_s = (cnt_r == 5'd15) ? FULL : DATA;
          end else if (sclk_fall_s && cnt_r >= 5'd9) begin
            tx_nxt_s = {tx_r[6:0], 1'b0};
          end else begin
            state_nxt_s = DATA;
          end
        end
        FULL: begin
          if (sclk_rise_s) begin
            state_nxt_s = OVER;
          end else if (sclk_fall_s) begin
            tx_nxt_s = {tx_r[6:0], 1'b0};
          end else begin
            state_nxt_s = FULL;
          end
        end
        OVER:    state_nxt_s = OVER;
        default: state_nxt_s = IDLE;
      endcase
    end
    miso_nxt_s = (state_nxt_s == DATA || state_nxt_s == FULL) ? tx_nxt_s[7] : 1'b0;
  end

  // Synchronizers, FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_r   <= 3'b111;
      sclk_sync_r <= 3'b111;
      mosi_sync_r <= 2'b00;
      state_r     <= IDLE;
      cnt_r       <= 5'd0;
      rx_r        <= 16'h0000;
      tx_r        <= 8'h00;
      rnw_r       <= 1'b0;
      addr_r      <= 7'h00;
      frame_r     <= 16'h0000;
      done_r      <= 1'b0;
      wr_strb_r   <= 1'b0;
      wr_addr_r   <= 7'h00;
      wr_data_r   <= 8'h00;
      miso_r      <= 1'b0;
    end else begin
      ss_sync_r   <= {ss_sync_r[1:0], SS_n};
      sclk_sync_r <= {sclk_sync_r[1:0], SCLK};
      mosi_sync_r <= {mosi_sync_r[0], MOSI};
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rx_r        <= rx_nxt_s;
      tx_r        <= tx_nxt_s;
      rnw_r       <= rnw_nxt_s;
      addr_r      <= addr_nxt_s;
      frame_r     <= frame_nxt_s;
      done_r      <= done_nxt_s;
      wr_strb_r   <= wr_strb_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      miso_r      <= miso_nxt_s;
    end
  end

  // Writable register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_s && wr_addr_nxt_s == 7'(i)) regs_r[i] <= wr_data_nxt_s;
      end
    end
  end

  assign MISO     = miso_r;
  assign done     = done_r;
  assign rx_frame = frame_r;
  assign wr_strb  = wr_strb_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;

endmodule

// File: tb/tb_spi_serf.sv
// Bench for spi_serf: drives SPI frames as a monarch would and scoreboards
// frame-end events and read-back bytes against a bench-side register model.
module tb_spi_serf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        done;
  logic [15:0] rx_frame;
  logic        wr_strb;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  logic [15:0] last_frame = 16'h0000;
  logic [7:0]  exp_regs [15];

  typedef struct {
    logic [15:0] frame;
    logic        wr;
    logic [6:0]  a;
    logic [7:0]  d;
  } ev_t;
  ev_t exp_q[$];

  spi_serf dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .done(done), .rx_frame(rx_frame), .wr_strb(wr_strb),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every done pops one expected frame-end event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        n_done++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done with rx_frame=%h, required no done", rx_frame);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (rx_frame !== e.frame) begin
            errors++;
            $display("FAIL rx_frame: got %h, required %h", rx_frame, e.frame);
          end
          checks++;
          if (wr_strb !== e.wr) begin
            errors++;
            $display("FAIL wr_strb_at_done: got %b, required %b (frame %h)", wr_strb, e.wr, e.frame);
          end
          if (e.wr) begin
            checks++;
            if (wr_addr !== e.a || wr_data !== e.d) begin
              errors++;
              $display("FAIL wr_addr_data: got %h/%h, required %h/%h", wr_addr, wr_data, e.a, e.d);
            end
          end
          last_frame = e.frame;
        end
      end else if (wr_strb) begin
        checks++;
        errors++;
        $display("FAIL stray_wr_strb: got wr_strb=1 without done, required 0");
      end
    end
  end

  function automatic logic [7:0] exp_rd(input logic [6:0] a);
    if (a == 7'h0F) return 8'h6A;
    else if (a < 7'd15) return exp_regs[a[3:0]];
    else return 8'h00;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one SS_n window with nrise SCLK rises; returns bits seen on rises 9..16.
  task automatic spi_frame(input logic [15:0] w, input int nrise,
                           output logic [7:0] rd, output logic miso_end);
    if (nrise == 16) begin
      ev_t e;
      e.frame = w;
      e.wr    = !w[15] && (w[14:8] < 7'd15);
      e.a     = w[14:8];
      e.d     = w[7:0];
      if (e.wr) exp_regs[e.a[3:0]] = e.d;
      exp_q.push_back(e);
    end
    rd = 8'h00;
    SS_n = 1'b0;
    wait_clk(10);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? w[15-i] : 1'b0;
      wait_clk(10);
      if (i >= 8 && i < 16) rd[15-i] = MISO;
      SCLK = 1'b1;
      wait_clk(10);
    end
    miso_end = MISO;
    SS_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic check_q_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d outstanding frame ends, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 15; i++) exp_regs[i] = 8'h00;
    wait_clk(3);
    checks++;
    if ({MISO, done, rx_frame, wr_strb, wr_addr, wr_data} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: got MISO=%b done=%b rx=%h strb=%b a=%h d=%h, required all 0",
               MISO, done, rx_frame, wr_strb, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_read_id;
    logic [7:0] rd; logic me; int d0;
    d0 = n_done;
    spi_frame(16'h8F00, 16, rd, me);
    checks++;
    if (rd !== 8'h6A) begin
      errors++;
      $display("FAIL read_id: got %h, required %h", rd, 8'h6A);
    end
    checks++;
    if (n_done - d0 != 1) begin
      errors++;
      $display("FAIL read_id_done_count: got %0d, required 1", n_done - d0);
    end
    check_q_empty("read_id");
  endtask

  task automatic test_write_read;
    logic [7:0] rd; logic me;
    spi_frame(16'h0655, 16, rd, me);
    spi_frame(16'h8600, 16, rd, me);
    checks++;
    if (rd !== exp_rd(7'h06)) begin
      errors++;
      $display("FAIL write_read_06: got %h, required %h", rd, exp_rd(7'h06));
    end
    spi_frame(16'h0EA5, 16, rd, me);
    spi_frame(16'h00C3, 16, rd, me);
    spi_frame(16'h8E00, 16, rd, me);
    checks++;
    if (rd !== exp_rd(7'h0E)) begin
      errors++;
      $display("FAIL write_read_0E: got %h, required %h", rd, exp_rd(7'h0E));
    end
    spi_frame(16'h8000, 16, rd, me);
    checks++;
    if (rd !== exp_rd(7'h00)) begin
      errors++;
      $display("FAIL write_read_00: got %h, required %h", rd, exp_rd(7'h00));
    end
    check_q_empty("write_read");
  endtask

  task automatic test_readonly_unmapped;
    logic [7:0] rd; logic me;
    spi_frame(16'h0F12, 16, rd, me);
    spi_frame(16'h1A33, 16, rd, me);
    spi_frame(16'h8F00, 16, rd, me);
    checks++;
    if (rd !== 8'h6A) begin
      errors++;
      $display("FAIL id_after_write: got %h, required %h", rd, 8'h6A);
    end
    spi_frame(16'h9A00, 16, rd, me);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL read_unmapped: got %h, required %h", rd, 8'h00);
    end
    check_q_empty("readonly");
  endtask

  task automatic test_abort;
    logic [7:0] rd; logic me; int d0;
    d0 = n_done;
    spi_frame(16'h0377, 10, rd, me);
    checks++;
    if (n_done != d0) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses, required 0", n_done - d0);
    end
    checks++;
    if (rx_frame !== last_frame) begin
      errors++;
      $display("FAIL abort_rx_frame: got %h, required %h", rx_frame, last_frame);
    end
    spi_frame(16'h8300, 16, rd, me);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL read_after_abort: got %h, required %h", rd, 8'h00);
    end
    check_q_empty("abort");
  endtask

  task automatic test_overlength;
    logic [7:0] rd; logic me; int d0;
    d0 = n_done;
    spi_frame(16'h0533, 17, rd, me);
    checks++;
    if (me !== 1'b0) begin
      errors++;
      $display("FAIL over_miso: got %b, required 0", me);
    end
    checks++;
    if (n_done != d0) begin
      errors++;
      $display("FAIL over_done: got %0d done pulses, required 0", n_done - d0);
    end
    spi_frame(16'h8500, 16, rd, me);
    checks++;
    if (rd !== exp_rd(7'h05)) begin
      errors++;
      $display("FAIL read_after_over: got %h, required %h", rd, exp_rd(7'h05));
    end
    spi_frame(16'h8600, 16, rd, me);
    checks++;
    if (rd !== exp_rd(7'h06)) begin
      errors++;
      $display("FAIL read_06_after_over: got %h, required %h", rd, exp_rd(7'h06));
    end
    check_q_empty("overlength");
  endtask

  task automatic test_reset_midframe;
    logic [7:0] rd; logic me; int d0;
    logic [15:0] w;
    w = 16'h04AA;
    d0 = n_done;
    SS_n = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 12; i++) begin
      SCLK = 1'b0;
      MOSI = w[15-i];
      wait_clk(10);
      SCLK = 1'b1;
      wait_clk(10);
    end
    rst_n = 1'b0;
    wait_clk(2);
    checks++;
    if ({MISO, done, rx_frame, wr_strb, wr_addr, wr_data} !== 34'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got MISO=%b done=%b rx=%h strb=%b a=%h d=%h, required all 0",
               MISO, done, rx_frame, wr_strb, wr_addr, wr_data);
    end
    SS_n = 1'b1;
    SCLK = 1'b1;
    for (int i = 0; i < 15; i++) exp_regs[i] = 8'h00;
    last_frame = 16'h0000;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    checks++;
    if (n_done != d0) begin
      errors++;
      $display("FAIL midreset_done: got %0d done pulses, required 0", n_done - d0);
    end
    spi_frame(16'h8400, 16, rd, me);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL read_04_after_reset: got %h, required %h", rd, 8'h00);
    end
    spi_frame(16'h8600, 16, rd, me);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL regs_cleared_by_reset: got %h, required %h", rd, 8'h00);
    end
    check_q_empty("midreset");
  endtask

  task automatic test_back_to_back;
    logic [7:0] rd; logic me; int d0;
    logic [15:0] w;
    d0 = n_done;
    for (int k = 0; k < 6; k++) begin
      logic [6:0] a;
      a = 7'($urandom_range(0, 14));
      w = {1'b0, a, 8'($urandom_range(0, 255))};
      spi_frame(w, 16, rd, me);
      spi_frame({1'b1, a, 8'h00}, 16, rd, me);
      checks++;
      if (rd !== exp_rd(a)) begin
        errors++;
        $display("FAIL b2b_read_%0d: got %h, required %h (addr %h)", k, rd, exp_rd(a), a);
      end
    end
    checks++;
    if (n_done - d0 != 12) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, required 12", n_done - d0);
    end
    check_q_empty("b2b");
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_write_read();
    test_readonly_unmapped();
    test_abort();
    test_overlength();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
